// File: rtl/root_pkg.sv
// root_pkg: shared constants and types for the square-root request sequencer.
//   RADICAND_W / ROOT_W / REM_W : datapath widths of the attached root unit
//   root_state_t               : sequencer FSM states
//   root_req_t                 : queued request {d, tag} at the default tag width
package root_pkg;

    localparam int RADICAND_W = 32;
    localparam int ROOT_W     = 16;
    localparam int REM_W      = 17;
    localparam int DEF_TAG_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2
    } root_state_t;

    typedef struct packed {
        logic [RADICAND_W-1:0] d;
        logic [DEF_TAG_W-1:0]  tag;
    } root_req_t;

endpackage

// File: rtl/root_req_fifo.sv
// root_req_fifo: synchronous DEPTH-entry request FIFO, first-word-fall-through
// head, asynchronous active-low clear of the pointers.
//   clk, clrn        : clock / async active-low clear
//   push, push_data  : write one entry (never asserted while full)
//   pop              : drop the head entry (never asserted while empty)
//   head             : current head entry
//   full, empty      : occupancy flags
//   count            : occupancy, 0..DEPTH
module root_req_fifo
    import root_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type req_t = root_req_t
) (
    input  logic                     clk,
    input  logic                     clrn,
    input  logic                     push,
    input  req_t                     push_data,
    input  logic                     pop,
    output req_t                     head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    req_t        mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    // Pointers carry one extra wrap bit so full and empty stay distinct.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    assign head  = mem[rd_ptr[AW-1:0]];
    assign count = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/root_sequencer.sv
// root_sequencer: queues radicand requests, feeds them one at a time to the
// iterative square-root unit with a single-cycle load pulse, and returns the
// results in order through a one-entry output slot.
//   clk, clrn                          : clock / async active-low reset
//   req_valid/req_ready/req_d/req_tag  : request channel (valid/ready)
//   rsp_valid/rsp_ready/rsp_q/rsp_r/
//   rsp_tag/rsp_exact                  : response channel (valid/ready)
//   pending                            : request FIFO occupancy
//   root_d/root_load                   : radicand and start pulse to the root unit
//   root_busy/root_ready/root_q/root_r : status and result from the root unit
module root_sequencer
    import root_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                    clk,
    input  logic                    clrn,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [RADICAND_W-1:0]   req_d,
    input  logic [TAG_W-1:0]        req_tag,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ROOT_W-1:0]       rsp_q,
    output logic [REM_W-1:0]        rsp_r,
    output logic [TAG_W-1:0]        rsp_tag,
    output logic                    rsp_exact,
    output logic [$clog2(DEPTH):0]  pending,
    output logic [RADICAND_W-1:0]   root_d,
    output logic                    root_load,
    input  logic                    root_busy,
    input  logic                    root_ready,
    input  logic [ROOT_W-1:0]       root_q,
    input  logic [REM_W-1:0]        root_r
);

    // Same layout as root_req_t, sized to this instance's tag width.
    typedef struct packed {
        logic [RADICAND_W-1:0] d;
        logic [TAG_W-1:0]      tag;
    } req_t;

    root_state_t      state;
    root_state_t      nxt;
    req_t             push_data;
    req_t             head;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             slot_free;
    logic             capture;
    logic [TAG_W-1:0] inflight_tag;

    assign req_ready = !full;
    assign push      = req_valid && req_ready;
    assign push_data = '{d: req_d, tag: req_tag};

    root_req_fifo #(
        .DEPTH (DEPTH),
        .req_t (req_t)
    ) u_fifo (
        .clk       (clk),
        .clrn      (clrn),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (pending)
    );

    // The slot can take a new result if it is empty or drains this cycle.
    assign slot_free = !rsp_valid || rsp_ready;
    assign capture   = (state == WAIT) && root_ready && !root_busy && slot_free;

    // FSM: state register
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) state <= IDLE;
        else       state <= nxt;
    end

    // FSM: next state
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (!empty) nxt = LOAD;
            LOAD:    nxt = WAIT;
            WAIT:    if (capture) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        root_load = 1'b0;
        pop       = 1'b0;
        if (state == LOAD) begin
            root_load = 1'b1;
            pop       = 1'b1;
        end
    end

    // root_d is registered on entry to LOAD so it only moves once per request.
    // The in-flight tag is taken from the head just before it is popped.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            root_d       <= '0;
            inflight_tag <= '0;
        end else begin
            if (state == IDLE && !empty) root_d <= head.d;
            if (state == LOAD)           inflight_tag <= head.tag;
        end
    end

    // Output slot: a capture in the same cycle as a transfer reloads it.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            rsp_valid <= 1'b0;
            rsp_q     <= '0;
            rsp_r     <= '0;
            rsp_tag   <= '0;
            rsp_exact <= 1'b0;
        end else if (capture) begin
            rsp_valid <= 1'b1;
            rsp_q     <= root_q;
            rsp_r     <= root_r;
            rsp_tag   <= inflight_tag;
            rsp_exact <= (root_r == '0);
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: doc/root_sequencer.md
# root_sequencer

Request sequencer that sits directly upstream of the 32-bit non-restoring square-root unit, and also consumes its results. It queues radicand requests on a valid/ready interface and issues one-cycle `load` pulses to the root unit. When the root unit signals completion, it captures root and remainder and returns them, tagged and in order, on a valid/ready response interface. It decouples producers from the root unit's 16-cycle iterative latency and its lack of input buffering.

## Interface
Parameters:
- DEPTH, 4: request FIFO entries; power of two, ≥2
- TAG_W, 4: width of the opaque request tag returned with each result

Ports:
- clk  in  1  clock, rising edge
- clrn  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  FIFO not full; transfer on req_valid & req_ready
- req_d  in  32  radicand
- req_tag  in  TAG_W  request tag
- rsp_valid  out  1  result held in output slot
- rsp_ready  in  1  consumer accepts; transfer on rsp_valid & rsp_ready
- rsp_q  out  16  root, floor(sqrt(d))
- rsp_r  out  17  remainder, d − q²
- rsp_tag  out  TAG_W  tag of that request
- rsp_exact  out  1  remainder == 0
- pending  out  $clog2(DEPTH)+1  FIFO occupancy
- root_d  out  32  radicand to root unit
- root_load  out  1  start pulse to root unit, exactly one cycle
- root_busy  in  1  root unit iterating
- root_ready  in  1  root unit result valid; held until next load
- root_q  in  16  root unit root
- root_r  in  17  root unit adjusted remainder

## Operation
- Request FIFO: DEPTH entries of {d, tag}. No bypass: every request passes through it. req_ready = !full. A push while full cannot occur.
- FSM states and transitions:
  - IDLE → LOAD when FIFO is non-empty.
  - LOAD lasts one cycle. It drives root_load=1 and root_d=head.d, pops the FIFO, and latches head.tag into an in-flight tag register. LOAD → WAIT.
  - WAIT: capture when root_ready & !root_busy & slot free. "Slot free" means rsp_valid==0 or a response transfer happens this cycle.
  - Capture loads rsp_q, rsp_r, rsp_tag, rsp_exact and sets rsp_valid. WAIT → IDLE.
  - If the slot is occupied, stay in WAIT. The root unit holds q/r stable until the next load, so nothing is lost.
- Overlap rule: up to one result in the output slot and one in flight in the root unit at the same time.
- Ordering: responses return strictly in request order.
- root_d is a don't-care outside LOAD. It holds its last value to avoid toggling.
- rsp_valid clears on a response transfer unless a capture happens in the same cycle. A same-cycle capture reloads the slot.
- rsp_* data is stable while rsp_valid & !rsp_ready.
- Reset clears all state mid-operation: FSM to IDLE, FIFO emptied, in-flight request discarded. The root unit shares clrn.

## Timing
- Reset values: req_ready=1, rsp_valid=0, rsp_q=0, rsp_r=0, rsp_tag=0, rsp_exact=0, pending=0, root_load=0, root_d=0.
- Latency with an idle FSM and free slot: request accepted at edge E0 → LOAD during cycle after E1 → root busy E2..E17 → root_ready after E18 → capture at E19. rsp_valid is high 19 edges after acceptance.
- Throughput: one result per 18 cycles (LOAD + 16 busy + WAIT capture); IDLE→LOAD adds one more cycle.
- pending updates on the edge after a push/pop. Push and pop in the same cycle leave it unchanged.
- FIFO pointers wrap modulo DEPTH. full/empty are distinguished by the extra occupancy bit.

## Structure
- Package root_pkg holds:
  - constants RADICAND_W=32, ROOT_W=16, REM_W=17
  - state enum {IDLE, LOAD, WAIT}
  - request struct {d, tag}
- One sub-module, root_req_fifo: synchronous DEPTH-entry FIFO with push/pop/full/empty/count and async active-low clear.
- root_sequencer does not instantiate the root unit. A bench top connects the two.

## Test plan
- req_d=144, tag=3, idle → rsp_valid 19 edges later with q=12, r=0, tag=3, exact=1.
- req_d=0xFFFF_FFFF → q=0xFFFF, r=0x1FFFE, exact=0. req_d=0 → q=0, r=0, exact=1.
- Hold rsp_ready=0 and push 6 requests back to back (DEPTH=4):
  - all 6 accepted, then req_ready=0 and pending=4
  - the second result is held in WAIT
  - after release, 6 responses return in order with correct tags
- Backpressure: rsp_ready=0 for 50 cycles with rsp_valid high → rsp_q, rsp_r, rsp_tag unchanged. Then a response transfer and a capture in the same cycle → the next result appears with no bubble.
- Pulse clrn low during WAIT with 3 pending:
  - all outputs reach their reset values immediately
  - after release, req_d=2 → q=1, r=1, exact=0, with no stale responses
- Random 1000 radicands with random valid/ready throttling → each result satisfies q²+r=d and r≤2q, in order; root_load is never high for two consecutive cycles.
